// File: rtl/uart_tx_fifo_reader.sv
// rtl/uart_tx_fifo_reader.sv - UART transmitter draining a FIFO read port
// Pops one word per frame in IDLE and serializes start/data(LSB first)/stop on Tick enables.
module uart_tx_fifo_reader #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICKS   = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Tick,
    input  logic                 FifoEmpty,
    input  logic [DATA_BITS-1:0] FifoReadData,
    output logic                 FifoRead,
    output logic                 Tx,
    output logic                 Busy,
    output logic                 TxDone
);

    localparam int MAX_TICKS = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        FifoRead = 1'b0;
        TxDone   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!FifoEmpty) begin
                    FifoRead = 1'b1;
                    shift_d  = FifoReadData;
                    tick_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (Tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (Tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            STOP: begin
                if (Tick) begin
                    if (tick_q == SB_LAST) begin
                        TxDone  = 1'b1;
                        tick_d  = '0;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobes are decoded combinationally, so keep them quiet while reset is held.
        if (Reset) begin
            FifoRead = 1'b0;
            TxDone   = 1'b0;
        end
        // The line level is registered from the next state to keep Tx glitch-free.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign Tx   = tx_q;
    assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb/tb_uart_tx_fifo_reader.sv - self-checking bench for uart_tx_fifo_reader
// A frame model indexed by Tick count predicts line level, strobes and busy every clock.
module tb_uart_tx_fifo_reader;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic [6:0] fifo_data7;
    logic       sel = 1'b0;
    logic       rd0, tx0, busy0, done0, rd1, tx1, busy1, done1;
    logic       rd_s, tx_s, busy_s, done_s;

    assign fifo_data7 = fifo_data[6:0];
    assign rd_s   = sel ? rd1   : rd0;
    assign tx_s   = sel ? tx1   : tx0;
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;

    uart_tx_fifo_reader dut0 (
        .Clock(clk), .Reset(rst), .Tick(tick), .FifoEmpty(fifo_empty),
        .FifoReadData(fifo_data), .FifoRead(rd0), .Tx(tx0), .Busy(busy0), .TxDone(done0)
    );

    uart_tx_fifo_reader #(.DATA_BITS(7), .OVERSAMPLE(16), .SB_TICKS(32)) dut1 (
        .Clock(clk), .Reset(rst), .Tick(tick), .FifoEmpty(fifo_empty),
        .FifoReadData(fifo_data7), .FifoRead(rd1), .Tx(tx1), .Busy(busy1), .TxDone(done1)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] fq[$];
    logic [7:0] decoded[$];
    int         rd_cycles[$];
    int         done_cycles[$];
    bit         in_frame = 1'b0;
    int         k = 0;
    int         db = 8;
    int         sb = 16;
    logic [7:0] cur_word = 8'h00;
    logic [7:0] dec = 8'h00;
    int         cyc = 0;
    int         tick_period = 4;
    int         tick_cnt = 0;
    bit         tick_rand = 1'b0;

    function automatic int total();
        return (1 + db) * OS + sb;
    endfunction

    function automatic logic level(int kk);
        if (kk < OS) return 1'b0;
        if (kk < (1 + db) * OS) return cur_word[(kk - OS) / OS];
        return 1'b1;
    endfunction

    task automatic cycle();
        logic exp_rd, exp_done, exp_tx;
        @(negedge clk);
        if (tick_rand) begin
            tick = ($urandom_range(0, 2) == 0);
        end else begin
            tick = (tick_cnt == 0);
            tick_cnt = (tick_cnt + 1) % tick_period;
        end
        fifo_empty = (fq.size() == 0);
        fifo_data = fifo_empty ? 8'($urandom) : fq[0];
        #1;
        exp_rd   = !rst && !in_frame && !fifo_empty;
        exp_done = !rst && in_frame && tick && (k == total() - 1);
        checks += 2;
        if (rd_s !== exp_rd) begin
            failures++;
            if (failures < 30) $display("FAIL fifo_read cyc=%0d got=%b expected=%b", cyc, rd_s, exp_rd);
        end
        if (done_s !== exp_done) begin
            failures++;
            if (failures < 30) $display("FAIL tx_done cyc=%0d got=%b expected=%b", cyc, done_s, exp_done);
        end
        if (rd_s === 1'b1) rd_cycles.push_back(cyc);
        if (done_s === 1'b1) done_cycles.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            in_frame = 1'b0;
        end else if (exp_rd) begin
            in_frame = 1'b1;
            k = 0;
            cur_word = fq.pop_front();
            dec = 8'h00;
        end else if (in_frame && tick) begin
            k++;
            if (k >= OS && k < (1 + db) * OS && ((k - OS) % OS) == OS / 2) dec[(k - OS) / OS] = tx_s;
            if (k == total()) begin
                in_frame = 1'b0;
                decoded.push_back(dec);
            end
        end
        exp_tx = in_frame ? level(k) : 1'b1;
        checks += 2;
        if (tx_s !== exp_tx) begin
            failures++;
            if (failures < 30) $display("FAIL tx_line cyc=%0d k=%0d got=%b expected=%b", cyc, k, tx_s, exp_tx);
        end
        if (busy_s !== in_frame) begin
            failures++;
            if (failures < 30) $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy_s, in_frame);
        end
    endtask

    task automatic clear_stats();
        decoded.delete();
        rd_cycles.delete();
        done_cycles.delete();
    endtask

    task automatic run_until_done(int n, int max_cyc, string name);
        int i = 0;
        while (done_cycles.size() < n && i < max_cyc) begin
            cycle();
            i++;
        end
        checks++;
        if (done_cycles.size() < n) begin
            failures++;
            $display("FAIL %s_timeout done=%0d expected=%0d", name, done_cycles.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick_rand = 1'b1;
        fq.push_back(8'h5A);
        repeat (24) cycle();
        fq.delete();
        tick_rand = 1'b0;
        rst = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic test_single_byte();
        clear_stats();
        tick_period = 4;
        tick_cnt = 0;
        fq.push_back(8'hA5);
        run_until_done(1, 800, "single");
        repeat (8) cycle();
        checks += 2;
        if (rd_cycles.size() != 1) begin
            failures++;
            $display("FAIL single_reads got=%0d expected=1", rd_cycles.size());
        end
        if (decoded.size() != 1 || decoded[0] !== 8'hA5) begin
            failures++;
            $display("FAIL single_word got=%0h expected=a5", (decoded.size() > 0) ? decoded[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        fq.push_back(8'h01);
        fq.push_back(8'h80);
        run_until_done(2, 1600, "b2b");
        repeat (40) cycle();
        checks += 3;
        if (rd_cycles.size() != 2) begin
            failures++;
            $display("FAIL b2b_reads got=%0d expected=2", rd_cycles.size());
        end else if (done_cycles.size() < 1 || rd_cycles[1] - done_cycles[0] != 1) begin
            failures++;
            $display("FAIL b2b_gap got=%0d expected=1", rd_cycles[1] - ((done_cycles.size() > 0) ? done_cycles[0] : 0));
        end
        if (decoded.size() != 2 || decoded[0] !== 8'h01 || decoded[1] !== 8'h80) begin
            failures++;
            $display("FAIL b2b_words got_count=%0d expected=01,80", decoded.size());
        end
        if (done_cycles.size() != 2) begin
            failures++;
            $display("FAIL b2b_done got=%0d expected=2", done_cycles.size());
        end
    endtask

    task automatic test_empty();
        clear_stats();
        repeat (2000) cycle();
        checks++;
        if (rd_cycles.size() != 0 || done_cycles.size() != 0) begin
            failures++;
            $display("FAIL empty_activity reads=%0d dones=%0d expected=0", rd_cycles.size(), done_cycles.size());
        end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] w2;
        int i = 0;
        clear_stats();
        w2 = 8'($urandom);
        fq.push_back(8'h3C);
        fq.push_back(w2);
        while (!(in_frame && k == 4 * OS + 6) && i < 1000) begin
            cycle();
            i++;
        end
        checks++;
        if (!(in_frame && k == 4 * OS + 6)) begin
            failures++;
            $display("FAIL midreset_reach got_k=%0d expected=%0d", k, 4 * OS + 6);
        end
        #2 rst = 1'b1;
        #1;
        in_frame = 1'b0;
        checks += 3;
        if (tx_s !== 1'b1) begin
            failures++;
            $display("FAIL midreset_tx got=%b expected=1", tx_s);
        end
        if (busy_s !== 1'b0) begin
            failures++;
            $display("FAIL midreset_busy got=%b expected=0", busy_s);
        end
        if (rd_s !== 1'b0) begin
            failures++;
            $display("FAIL midreset_read got=%b expected=0", rd_s);
        end
        repeat (6) cycle();
        rst = 1'b0;
        clear_stats();
        run_until_done(1, 1000, "midreset");
        repeat (4) cycle();
        checks += 2;
        if (rd_cycles.size() != 1) begin
            failures++;
            $display("FAIL midreset_reads got=%0d expected=1", rd_cycles.size());
        end
        if (decoded.size() != 1 || decoded[0] !== w2) begin
            failures++;
            $display("FAIL midreset_word got=%0h expected=%0h", (decoded.size() > 0) ? decoded[0] : 8'hxx, w2);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] words[4];
        clear_stats();
        tick_rand = 1'b1;
        for (int i = 0; i < 4; i++) begin
            words[i] = 8'($urandom);
            fq.push_back(words[i]);
        end
        run_until_done(4, 9000, "random");
        repeat (10) cycle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (decoded.size() <= i || decoded[i] !== words[i]) begin
                failures++;
                $display("FAIL random_word%0d got=%0h expected=%0h", i, (decoded.size() > i) ? decoded[i] : 8'hxx, words[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (rd_cycles.size() <= i || done_cycles.size() < i || rd_cycles[i] - done_cycles[i-1] != 1) begin
                failures++;
                $display("FAIL random_gap%0d reads=%0d dones=%0d expected_gap=1", i, rd_cycles.size(), done_cycles.size());
            end
        end
        tick_rand = 1'b0;
    endtask

    task automatic test_param();
        rst = 1'b1;
        repeat (3) cycle();
        sel = 1'b1;
        db = 7;
        sb = 32;
        tick_period = 4;
        tick_cnt = 0;
        rst = 1'b0;
        clear_stats();
        fq.push_back(8'h55);
        run_until_done(1, 1000, "param");
        repeat (8) cycle();
        checks += 2;
        if (rd_cycles.size() != 1 || done_cycles.size() != 1) begin
            failures++;
            $display("FAIL param_strobes reads=%0d dones=%0d expected=1", rd_cycles.size(), done_cycles.size());
        end
        if (decoded.size() != 1 || decoded[0] !== 8'h55) begin
            failures++;
            $display("FAIL param_word got=%0h expected=55", (decoded.size() > 0) ? decoded[0] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_empty();
        test_reset_mid_data();
        test_random_stream();
        test_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
UART transmitter that drains a transmit FIFO and serializes each byte onto a single line.
- Sits on the read side of the existing Fifo: watches its Empty flag, pops one word per frame, and emits start / data (LSB first) / stop at the baud rate.
- Baud timing comes from an external oversampling tick enable shared with the receive path.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9)
OVERSAMPLE, 16, Tick pulses per start bit and per data bit
SB_TICKS, 16, Tick pulses for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Tick  input  1  one-Clock-wide enable at OVERSAMPLE x baud rate
FifoEmpty  input  1  FIFO empty flag
FifoReadData  input  DATA_BITS  FIFO head word, valid combinationally whenever FifoEmpty=0
FifoRead  output  1  one-cycle pop strobe to the FIFO
Tx  output  1  serial line, idle high
Busy  output  1  high while a frame is in progress (state != IDLE)
TxDone  output  1  one-cycle pulse when the stop period completes

Behaviour:
- Reset (async, immediate): state=IDLE; Tx=1; FifoRead=0; Busy=0; TxDone=0; tick count, bit count and shift register cleared.
- Tx comes from a flop, so there are no combinational glitches on the line.
- FifoRead and TxDone are combinational decodes of state and counters; they are never asserted while Reset=1.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - Tx=1.
  - If FifoEmpty=0: assert FifoRead for exactly this cycle, load FifoReadData into the shift register, clear the tick count, go to START.
  - Tick is ignored in IDLE.
- START:
  - Tx=0 from the first cycle after the FifoRead cycle (latency 1 Clock).
  - On a Tick with tick count = OVERSAMPLE-1: clear the tick count and bit count, go to DATA. Otherwise, on a Tick, increment the tick count.
- DATA:
  - Tx=shift[0].
  - On a Tick with tick count = OVERSAMPLE-1: shift right by one, increment the bit count, clear the tick count.
  - If the bit count was DATA_BITS-1, go to STOP instead.
- STOP:
  - Tx=1.
  - On a Tick with tick count = SB_TICKS-1: pulse TxDone in that cycle, go to IDLE.
- Frame length: (1+DATA_BITS)*OVERSAMPLE + SB_TICKS Tick pulses. Clock cycles without Tick do not advance any counter.
- Back-to-back frames:
  - IDLE is always entered for at least one Clock after STOP.
  - If FifoEmpty=0 in that cycle, the next FifoRead fires immediately, giving one Clock of extra idle-high between frames.
  - There is never more than one FifoRead per frame.
- FifoEmpty and FifoReadData are sampled only in IDLE. Changes mid-frame have no effect; the latched word is transmitted intact.
- Tick counter width is clog2(max(OVERSAMPLE, SB_TICKS)). Bit counter width is clog2(DATA_BITS). Both compare for equality only; no wrap is relied upon.
- Reset mid-frame:
  - The frame is abandoned and Tx returns to 1 asynchronously.
  - The popped word is lost; no re-read occurs.
  - After deassertion, a new frame starts only from IDLE with a fresh FifoRead.

Test Plan:
1. Reset check: assert Reset with Tick toggling and FifoEmpty=0 -> Tx=1, FifoRead=0, Busy=0, TxDone=0 throughout Reset.
2. Single byte, defaults, Tick every 4 Clocks, one entry 0xA5 -> one FifoRead pulse, then:
   - Tx low for 16 Ticks;
   - then 1,0,1,0,0,1,0,1 for 16 Ticks each;
   - then high for 16 Ticks;
   - TxDone pulses once, 160 Ticks after the start bit began; Busy low on the next Clock.
3. Back-to-back: FIFO holds 0x01, 0x80 -> exactly two FifoRead pulses.
   - The second pulse comes 1 Clock after the first TxDone.
   - The decoded frames read 0x01 then 0x80.
   - No third pop when FifoEmpty=1.
4. Empty FIFO: FifoEmpty=1 held for 500 Ticks -> Tx stays 1, FifoRead never asserts, Busy=0.
5. Reset mid-DATA: assert Reset at bit 3 of 0x3C -> Tx=1 in the same cycle, state IDLE.
   - After release with FifoEmpty=0, the next frame starts with a new FifoRead and a full 16-Tick start bit.
6. Parameterized: DATA_BITS=7, SB_TICKS=32, byte 0x55 ->
   - 7 data bits 1,0,1,0,1,0,1;
   - stop high for 32 Ticks;
   - total 160 Ticks; TxDone pulses once.
